// File: rtl/register_file_mp.sv
// Parametrised multi-port register file: byte-enable writes, registered reads with
// valid strobes, selectable write-first/read-first, optional hardwired-zero entry 0.

module register_file_mp_rd #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvalid_o
);
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;

    // rdata only loads on a request so idle ports don't toggle
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= en_i;
            if (en_i) rdata_q <= data_i;
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
endmodule

module register_file_mp #(
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 64,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD-1:0]          read_en,
    input  logic [NUM_RD*AW-1:0]       raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    output logic [NUM_RD-1:0]          rvalid,
    input  logic [NUM_WR-1:0]          write_en,
    input  logic [NUM_WR*AW-1:0]       waddr,
    input  logic [NUM_WR*DATA_W-1:0]   wdata,
    input  logic [NUM_WR*DATA_W/8-1:0] wbe
);
    localparam int            NB      = DATA_W / 8;
    localparam logic [AW:0]   DEPTH_V = (AW+1)'(DEPTH);

    logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
    logic [NUM_WR-1:0]            wr_ok;

    for (genvar w = 0; w < NUM_WR; w++) begin : g_wr
        logic [AW-1:0] wa;
        assign wa       = waddr[w*AW +: AW];
        assign wr_ok[w] = write_en[w] && ({1'b0, wa} < DEPTH_V)
                          && !((ZERO_REG != 0) && (wa == '0));
    end

    // Ports applied in ascending order so the highest-index port wins each byte
    always_comb begin
        mem_d = mem_q;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_ok[w]) begin
                for (int b = 0; b < NB; b++) begin
                    if (wbe[w*NB + b])
                        mem_d[waddr[w*AW +: AW]][b*8 +: 8] = wdata[w*DATA_W + b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) mem_q <= '0;
        else       mem_q <= mem_d;
    end

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        logic [AW-1:0]     ra;
        logic              rd_ok;
        logic [DATA_W-1:0] rd_src, rd_sel;

        assign ra     = raddr[r*AW +: AW];
        assign rd_ok  = ({1'b0, ra} < DEPTH_V) && !((ZERO_REG != 0) && (ra == '0));
        // Write-first taps the merged next-state, so bypass sees collisions and byte enables
        assign rd_src = (BYPASS != 0) ? mem_d[ra] : mem_q[ra];
        assign rd_sel = rd_ok ? rd_src : '0;

        register_file_mp_rd #(.DATA_W(DATA_W)) u_rd (
            .clk      (clk),
            .reset    (reset),
            .en_i     (read_en[r]),
            .data_i   (rd_sel),
            .rdata_o  (rdata[r*DATA_W +: DATA_W]),
            .rvalid_o (rvalid[r])
        );
    end
endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: a write-first full-depth instance and a read-first,
// zero-register, 48-entry instance share one stimulus stream.

module tb_register_file_mp;
    localparam int DW = 64;
    localparam int AW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [1:0]      ren, wen;
    logic [2*AW-1:0] raddr, waddr;
    logic [2*DW-1:0] wdata;
    logic [15:0]     wbe;
    logic [2*DW-1:0] rd_a, rd_b;
    logic [1:0]      rv_a, rv_b;

    register_file_mp #(.DATA_W(64), .DEPTH(64), .NUM_RD(2), .NUM_WR(2), .BYPASS(1), .ZERO_REG(0)) dut_a (
        .clk(clk), .reset(rst), .read_en(ren), .raddr(raddr), .rdata(rd_a), .rvalid(rv_a),
        .write_en(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe));

    register_file_mp #(.DATA_W(64), .DEPTH(48), .NUM_RD(2), .NUM_WR(2), .BYPASS(0), .ZERO_REG(1)) dut_b (
        .clk(clk), .reset(rst), .read_en(ren), .raddr(raddr), .rdata(rd_b), .rvalid(rv_b),
        .write_en(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe));

    typedef struct {
        bit        rst;
        bit [1:0]  ren;
        bit [5:0]  ra0, ra1;
        bit [1:0]  wen;
        bit [5:0]  wa0, wa1;
        bit [63:0] wd0, wd1;
        bit [7:0]  be0, be1;
        bit [1:0]  ev;
        bit [63:0] ea, eb;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: architectural contents plus expected output registers
    logic [63:0] mem[2][64];
    logic [63:0] exr[2][2];
    logic        exv[2][2];
    int          dep[2] = '{64, 48};
    bit          byp[2] = '{1'b1, 1'b0};
    bit          zr[2]  = '{1'b0, 1'b1};

    function automatic vec_t mk(bit r, bit [1:0] re, int ra0, int ra1, bit [1:0] we, int wa0, int wa1,
                                logic [63:0] wd0, logic [63:0] wd1, bit [7:0] be0, bit [7:0] be1,
                                bit [1:0] ev, logic [63:0] ea, logic [63:0] eb);
        vec_t v;
        v.rst = r; v.ren = re; v.ra0 = 6'(ra0); v.ra1 = 6'(ra1);
        v.wen = we; v.wa0 = 6'(wa0); v.wa1 = 6'(wa1);
        v.wd0 = wd0; v.wd1 = wd1; v.be0 = be0; v.be1 = be1;
        v.ev = ev; v.ea = ea; v.eb = eb;
        return v;
    endfunction

    function automatic logic [63:0] bmask(logic [7:0] be);
        logic [63:0] m = '0;
        for (int b = 0; b < 8; b++) if (be[b]) m[b*8 +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic logic [63:0] peek(int i, int a);
        if (a >= dep[i] || (zr[i] && a == 0)) return 64'h0;
        return mem[i][a];
    endfunction

    task automatic check(input string nm, input logic [65:0] act, input logic [65:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    task automatic model(input vec_t v);
        int          ra[2], wa[2];
        logic [63:0] wd[2], pre[2], m;
        logic [7:0]  be[2];
        ra = '{int'(v.ra0), int'(v.ra1)};
        wa = '{int'(v.wa0), int'(v.wa1)};
        wd = '{v.wd0, v.wd1};
        be = '{v.be0, v.be1};
        for (int i = 0; i < 2; i++) begin
            if (v.rst) begin
                for (int e = 0; e < 64; e++) mem[i][e] = '0;
                for (int r = 0; r < 2; r++) begin exr[i][r] = '0; exv[i][r] = 1'b0; end
            end else begin
                for (int r = 0; r < 2; r++) pre[r] = peek(i, ra[r]);
                for (int w = 0; w < 2; w++) begin
                    if (v.wen[w] && wa[w] < dep[i] && !(zr[i] && wa[w] == 0)) begin
                        m = bmask(be[w]);
                        mem[i][wa[w]] = (mem[i][wa[w]] & ~m) | (wd[w] & m);
                    end
                end
                for (int r = 0; r < 2; r++) begin
                    exv[i][r] = v.ren[r];
                    if (v.ren[r]) exr[i][r] = byp[i] ? peek(i, ra[r]) : pre[r];
                end
            end
        end
    endtask

    // Drive one cycle, advance the model, compare every port of both instances
    task automatic apply(input vec_t v);
        rst   = v.rst;
        ren   = v.ren;
        raddr = {v.ra1, v.ra0};
        wen   = v.wen;
        waddr = {v.wa1, v.wa0};
        wdata = {v.wd1, v.wd0};
        wbe   = {v.be1, v.be0};
        model(v);
        @(posedge clk);
        @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            check($sformatf("model_A_p%0d", r), {1'b0, rv_a[r], rd_a[r*DW +: DW]}, {1'b0, exv[0][r], exr[0][r]});
            check($sformatf("model_B_p%0d", r), {1'b0, rv_b[r], rd_b[r*DW +: DW]}, {1'b0, exv[1][r], exr[1][r]});
        end
    endtask

    vec_t tv[19];
    vec_t rv;
    logic [63:0] walk;

    initial begin
        rst = 1'b1; ren = '0; raddr = '0; wen = '0; waddr = '0; wdata = '0; wbe = '0;

        tv[0]  = mk(1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        tv[1]  = mk(1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        tv[2]  = mk(0, 2'b00, 0, 0, 2'b01, 5, 0, 64'h1111_1111_1111_1111, 0, 8'hFF, 0, 2'b00, 0, 0);
        tv[3]  = mk(0, 2'b10, 0, 5, 2'b11, 5, 5, 64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB, 8'h0F, 8'h3C,
                    2'b10, 64'h1111_BBBB_BBBB_AAAA, 64'h1111_1111_1111_1111);
        tv[4]  = mk(0, 2'b10, 0, 5, 2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 64'h1111_BBBB_BBBB_AAAA, 64'h1111_BBBB_BBBB_AAAA);
        tv[5]  = mk(0, 2'b10, 0, 9, 2'b01, 9, 0, 64'hDEAD_BEEF_0000_0001, 0, 8'hFF, 0, 2'b10, 64'hDEAD_BEEF_0000_0001, 0);
        tv[6]  = mk(0, 2'b10, 0, 9, 2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001);
        tv[7]  = mk(0, 2'b00, 0, 9, 2'b01, 3, 0, 64'h33, 0, 8'hFF, 0, 2'b00, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001);
        tv[8]  = mk(0, 2'b10, 0, 3, 2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 64'h33, 64'h33);
        tv[9]  = mk(0, 2'b00, 0, 3, 2'b01, 3, 0, 64'h44, 0, 8'hFF, 0, 2'b00, 64'h33, 64'h33);
        tv[10] = mk(0, 2'b00, 0, 3, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 64'h33, 64'h33);
        tv[11] = mk(0, 2'b00, 0, 3, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 64'h33, 64'h33);
        tv[12] = mk(0, 2'b10, 0, 3, 2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 64'h44, 64'h44);
        tv[13] = mk(1, 2'b11, 7, 7, 2'b01, 7, 0, 64'h77, 0, 8'hFF, 0, 2'b00, 0, 0);
        tv[14] = mk(0, 2'b11, 7, 7, 2'b00, 0, 0, 0, 0, 0, 0, 2'b11, 0, 0);
        tv[15] = mk(0, 2'b00, 0, 0, 2'b11, 0, 50, 64'hFF, 64'hFF, 8'hFF, 8'hFF, 2'b00, 0, 0);
        tv[16] = mk(0, 2'b11, 0, 50, 2'b00, 0, 0, 0, 0, 0, 0, 2'b11, 64'hFF, 0);
        tv[17] = mk(0, 2'b00, 0, 1, 2'b01, 1, 0, 64'h5A5A, 0, 8'hFF, 0, 2'b00, 64'hFF, 0);
        // Write with no byte enables must leave the entry alone, even on the bypass path
        tv[18] = mk(0, 2'b10, 0, 1, 2'b01, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 8'h00, 0, 2'b10, 64'h5A5A, 64'h5A5A);

        for (int k = 0; k < 19; k++) begin
            apply(tv[k]);
            check($sformatf("tbl%0d_A", k), {rv_a, rd_a[2*DW-1:DW]}, {tv[k].ev, tv[k].ea});
            check($sformatf("tbl%0d_B", k), {rv_b, rd_b[2*DW-1:DW]}, {tv[k].ev, tv[k].eb});
        end

        // Walking ones in then zeros out, every address, write then read on all ports
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int a = 0; a < 64; a++) begin
            walk = '0;
            for (int k = 0; k < 128; k++) begin
                walk = {walk[62:0], (k < 64)};
                apply(mk(0, 2'b00, 0, 0, 2'b01, a, 0, walk, 0, 8'hFF, 0, 0, 0, 0));
                apply(mk(0, 2'b11, a, a, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            end
        end

        // Random traffic with frequent write collisions and occasional resets
        for (int n = 0; n < 3000; n++) begin
            rv = mk($urandom_range(0, 63) == 0, 2'($urandom_range(0, 3)),
                    $urandom_range(0, 63), $urandom_range(0, 63),
                    2'($urandom_range(0, 3)), $urandom_range(0, 63), $urandom_range(0, 63),
                    {$urandom, $urandom}, {$urandom, $urandom},
                    8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, 0, 0);
            if ($urandom_range(0, 1) == 1) rv.wa1 = rv.wa0;
            if ($urandom_range(0, 3) == 0) rv.ra1 = rv.wa0;
            if ($urandom_range(0, 7) == 0) rv.be0 = 8'h00;
            apply(rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
